// File: rtl/hazard_scoreboard_unit.sv
// Operand forwarding, load-use and mul/div scoreboard hazard detection for the in-order pipeline.
// Forwarding and stall outputs are combinational; only the scoreboard and stall counter hold state.
module hazard_scoreboard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  id_src_addr,
    input  logic [NUM_SRC-1:0]             id_src_used,
    input  logic [NUM_SRC-1:0]             id_src_late,
    input  logic                           id_md_start,
    input  logic [REG_ADDR_W-1:0]          id_md_dst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  ex_src_addr,
    input  logic                           ex_mem_read,
    input  logic [REG_ADDR_W-1:0]          ex_dst_addr,
    input  logic                           mem_reg_write,
    input  logic [REG_ADDR_W-1:0]          mem_dst_addr,
    input  logic                           mem_mem_write,
    input  logic [REG_ADDR_W-1:0]          mem_store_src,
    input  logic                           wb_reg_write,
    input  logic [REG_ADDR_W-1:0]          wb_dst_addr,
    input  logic                           wb_mem_read,
    output logic [NUM_SRC*2-1:0]           fwd_sel,
    output logic                           fwd_store,
    output logic                           stall,
    output logic                           md_busy,
    output logic [REG_ADDR_W-1:0]          md_dst_q,
    output logic [CNT_W-1:0]               stall_cycles
);

    localparam int unsigned MD_CNT_W = $clog2(MD_LATENCY + 1);

    logic [MD_CNT_W-1:0]    r_md_cnt;
    logic [REG_ADDR_W-1:0]  r_md_dst;
    logic [CNT_W-1:0]       r_stall_cnt;

    logic [NUM_SRC*2-1:0]   w_fwd_sel;
    logic                   w_fwd_store;
    logic                   w_load_use;
    logic                   w_md_dep;
    logic                   w_md_busy;
    logic                   w_stall;

    // Per-source hazard compare; register 0 is hard-wired and never matches.
    always_comb begin
        w_fwd_sel  = '0;
        w_load_use = 1'b0;
        w_md_dep   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mem_reg_write && (mem_dst_addr != '0) &&
                (mem_dst_addr == ex_src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                w_fwd_sel[2*i +: 2] = 2'b10;
            end else if (wb_reg_write && (wb_dst_addr != '0) &&
                         (wb_dst_addr == ex_src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                w_fwd_sel[2*i +: 2] = 2'b01;
            end
            if (ex_mem_read && (ex_dst_addr != '0) && id_src_used[i] && !id_src_late[i] &&
                (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == ex_dst_addr)) begin
                w_load_use = 1'b1;
            end
            if (id_src_used[i] && (r_md_dst != '0) &&
                (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == r_md_dst)) begin
                w_md_dep = 1'b1;
            end
        end
    end

    assign w_md_busy   = (r_md_cnt != '0);
    assign w_fwd_store = wb_mem_read && mem_mem_write && (wb_dst_addr != '0) &&
                         (mem_store_src == wb_dst_addr);
    // A busy unit blocks both dependent readers and any new mul/div issue.
    assign w_stall     = reset && (w_load_use || (w_md_busy && (w_md_dep || id_md_start)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_md_cnt    <= '0;
            r_md_dst    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (id_md_start && !w_stall) begin
                r_md_cnt <= MD_CNT_W'(MD_LATENCY);
                r_md_dst <= id_md_dst;
            end else if (w_md_busy) begin
                r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign fwd_sel      = reset ? w_fwd_sel : '0;
    assign fwd_store    = reset && w_fwd_store;
    assign stall        = w_stall;
    assign md_busy      = w_md_busy;
    assign md_dst_q     = r_md_dst;
    assign stall_cycles = r_stall_cnt;

endmodule
